// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the core's shared ALU for its adds.
// The core yields the ALU one granted cycle at a time; the product's low WIDTH bits return over valid/ready.
module alu_mul_sequencer #(
    parameter int unsigned WIDTH      = 64,
    parameter logic [3:0]  ADD_CODE   = 4'b0010,
    parameter logic [3:0]  PASSB_CODE = 4'b0111
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_zero,
    output logic             busy,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_w
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mplr_shift;

    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               result_zero_q, result_zero_d;
    logic               busy_q, busy_d;
    logic               alu_req_q, alu_req_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [3:0]         alu_ctrl_q, alu_ctrl_d;

    // Next-state datapath; outputs are decoded from the next register values so
    // the registered copies equal a Moore decode of the current state.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        cnt_d      = cnt_q;
        mplr_shift = mplr_q >> 1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mcand_d = op_a;
                    mplr_d  = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (op_b == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (alu_gnt) begin
                    acc_d   = alu_w;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_shift;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if ((mplr_shift == '0) || (cnt_q == CNT_W'(WIDTH - 1))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d   = (state_d == IDLE);
        resp_valid_d  = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        alu_req_d     = (state_d == ITER);
        alu_a_d       = '0;
        alu_b_d       = '0;
        alu_ctrl_d    = PASSB_CODE;
        result_d      = result_q;
        result_zero_d = result_zero_q;

        if (state_d == ITER) begin
            alu_a_d    = acc_d;
            alu_b_d    = mplr_d[0] ? mcand_d : '0;
            alu_ctrl_d = ADD_CODE;
        end

        // Result only moves when a product is published; it then holds through IDLE.
        if (state_d == DONE) begin
            result_d      = acc_d;
            result_zero_d = (acc_d == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplr_q        <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
            busy_q        <= 1'b0;
            alu_req_q     <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= PASSB_CODE;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplr_q        <= mplr_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
            busy_q        <= busy_d;
            alu_req_q     <= alu_req_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign result      = result_q;
    assign result_zero = result_zero_q;
    assign busy        = busy_q;
    assign alu_req     = alu_req_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU plus a product/partial-sum model
// built from plain multiplication of the operands.
module tb_alu_mul_sequencer;

    localparam int unsigned W     = 64;
    localparam logic [3:0]  ADD   = 4'b0010;
    localparam logic [3:0]  PASSB = 4'b0111;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  result;
    logic          result_zero;
    logic          busy;
    logic          alu_req;
    logic          alu_gnt;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_w;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_sequencer #(
        .WIDTH      (W),
        .ADD_CODE   (ADD),
        .PASSB_CODE (PASSB)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .result      (result),
        .result_zero (result_zero),
        .busy        (busy),
        .alu_req     (alu_req),
        .alu_gnt     (alu_gnt),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_w       (alu_w)
    );

    // Shared datapath ALU as seen by the sequencer.
    assign alu_w = (alu_ctrl == ADD) ? (alu_a + alu_b) : alu_b;

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Number of shift-add steps: one per bit up to the highest set bit of b.
    function automatic int nbits(input logic [W-1:0] b);
        int n = 0;
        for (int j = 0; j < W; j++) if (b[j]) n = j + 1;
        return n;
    endfunction

    // Accumulator value before step i: a times the low i bits of b.
    function automatic logic [W-1:0] partial(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        logic [W-1:0] mask;
        mask = (64'd1 << i) - 64'd1;
        return a * (b & mask);
    endfunction

    function automatic logic [W-1:0] term(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        return b[i] ? (a << i) : 64'd0;
    endfunction

    // Full transaction: accept, shift-add steps with grant pattern, response hold, consume.
    task automatic mul_scenario(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int stall_first, input bit rand_gnt, input int hold);
        logic [W-1:0] prod;
        int n;
        int i;
        int cyc;
        bit gnt;
        prod = a * b;
        n    = nbits(b);
        i    = 0;
        cyc  = 0;

        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: req_ready=%b busy=%b resp_valid=%b, expected 1 0 0", name, req_ready, busy, resp_valid);
        end
        req_valid  = 1'b1;
        op_a       = a;
        op_b       = b;
        resp_ready = 1'b0;
        alu_gnt    = 1'($urandom_range(0, 1));
        tick();

        while (i < n && cyc < 1000) begin
            req_valid = 1'($urandom_range(0, 1));
            op_a      = {$urandom, $urandom};
            op_b      = {$urandom, $urandom};
            n_checks++;
            if (alu_req !== 1'b1 || alu_ctrl !== ADD || alu_a !== partial(a, b, i) || alu_b !== term(a, b, i)
                || resp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s step%0d: req=%b ctrl=%h a=%h b=%h rv=%b rr=%b busy=%b, expected 1 %h %h %h 0 0 1",
                         name, i, alu_req, alu_ctrl, alu_a, alu_b, resp_valid, req_ready, busy,
                         ADD, partial(a, b, i), term(a, b, i));
            end
            gnt = (cyc < stall_first) ? 1'b0 : (rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1);
            alu_gnt = gnt;
            tick();
            if (gnt) i++;
            cyc++;
        end
        if (cyc >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d steps granted, expected %0d", name, i, n);
        end

        req_valid = 1'b0;
        alu_gnt   = 1'($urandom_range(0, 1));
        n_checks++;
        if (resp_valid !== 1'b1 || result !== prod || result_zero !== (prod == 64'd0) || alu_req !== 1'b0
            || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_ctrl !== PASSB || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: rv=%b result=%h zero=%b req=%b a=%h b=%h ctrl=%h busy=%b rr=%b, expected result=%h zero=%b",
                     name, resp_valid, result, result_zero, alu_req, alu_a, alu_b, alu_ctrl, busy, req_ready,
                     prod, (prod == 64'd0));
        end

        for (int k = 0; k < hold; k++) begin
            tick();
            n_checks++;
            if (resp_valid !== 1'b1 || result !== prod || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold%0d: rv=%b result=%h rr=%b, expected 1 %h 0", name, k, resp_valid, result, req_ready, prod);
            end
        end

        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || result !== prod) begin
            n_fail++;
            $display("FAIL %s consume: rv=%b rr=%b busy=%b result=%h, expected 0 1 0 %h", name, resp_valid, req_ready, busy, result, prod);
        end
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        alu_gnt    = 1'b0;
        op_a       = '0;
        op_b       = '0;
        tick();
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 64'd0 || result_zero !== 1'b1 || busy !== 1'b0
                || alu_req !== 1'b0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_ctrl !== PASSB) begin
                n_fail++;
                $display("FAIL reset%0d: rr=%b rv=%b result=%h zero=%b busy=%b req=%b a=%h b=%h ctrl=%h",
                         k, req_ready, resp_valid, result, result_zero, busy, alu_req, alu_a, alu_b, alu_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_basic();
        mul_scenario("basic_7x5", 64'd7, 64'd5, 0, 1'b0, 0);
        mul_scenario("zero_mcand", 64'd0, 64'd5, 0, 1'b0, 0);
        mul_scenario("one_by_one", 64'd1, 64'd1, 0, 1'b0, 0);
    endtask

    task automatic test_zero_mplr();
        mul_scenario("zero_mplr", 64'd123, 64'd0, 0, 1'b0, 0);
    endtask

    task automatic test_max();
        mul_scenario("max_msb", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1'b0, 0);
        mul_scenario("max_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 0);
    endtask

    task automatic test_stall();
        mul_scenario("stall_3x3", 64'd3, 64'd3, 2, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        mul_scenario("bp_6x9", 64'd6, 64'd9, 0, 1'b0, 3);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        op_a      = 64'h1234_5678_9ABC_DEF0;
        op_b      = 64'hFFFF_FFFF_FFFF_FFFF;
        alu_gnt   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (alu_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: req=%b busy=%b, expected 1 1", alu_req, busy);
        end
        Reset = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 64'd0 || result_zero !== 1'b1 || busy !== 1'b0
            || alu_req !== 1'b0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_ctrl !== PASSB) begin
            n_fail++;
            $display("FAIL reset_mid: rr=%b rv=%b result=%h zero=%b busy=%b req=%b a=%h b=%h ctrl=%h",
                     req_ready, resp_valid, result, result_zero, busy, alu_req, alu_a, alu_b, alu_ctrl);
        end
        Reset   = 1'b0;
        alu_gnt = 1'b0;
        tick();
        mul_scenario("after_reset", 64'd11, 64'd13, 0, 1'b1, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            b = b >> $urandom_range(0, 63);
            if (t % 6 == 5) b = '0;
            mul_scenario($sformatf("rand%0d", t), a, b, int'($urandom_range(0, 2)), 1'b1, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_mplr();
        test_max();
        test_stall();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle unsigned multiply controller that reuses the shared 64-bit datapath ALU for its adds (shift-add algorithm), so no separate multiplier array is needed.
- Sits beside the single-cycle core's execute stage.
- The core issues a request and yields the ALU by granting cycles.
- The sequencer drives the ALU operands/control, collects the low WIDTH bits of the product, and returns it via a valid/ready response.

Parameters:
WIDTH, 64, operand/result width; must match ALU bus width
ADD_CODE, 4'b0010, ALUCtrl encoding for add
PASSB_CODE, 4'b0111, ALUCtrl encoding for pass-B (idle drive)

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
req_valid  in  1  multiply request present
req_ready  out  1  sequencer can accept request
op_a  in  WIDTH  multiplicand, sampled on accept
op_b  in  WIDTH  multiplier, sampled on accept
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
result  out  WIDTH  low WIDTH bits of op_a*op_b
result_zero  out  1  result == 0
busy  out  1  high in ITER or DONE
alu_req  out  1  sequencer wants the ALU this cycle
alu_gnt  in  1  core grants ALU this cycle
alu_a  out  WIDTH  ALU BusA drive
alu_b  out  WIDTH  ALU BusB drive
alu_ctrl  out  4  ALU ALUCtrl drive
alu_w  in  WIDTH  ALU BusW result

Behaviour:
- State registers: state {IDLE, ITER, DONE}; acc, mcand, mplr (WIDTH each); cnt (log2(WIDTH) bits).
- Reset (synchronous; also applies mid-operation, abandoning any in-flight multiply):
  - state=IDLE; acc, mcand, mplr, cnt = 0.
  - Outputs: req_ready=1, resp_valid=0, result=0, result_zero=1, busy=0, alu_req=0, alu_a=0, alu_b=0, alu_ctrl=PASSB_CODE.
- IDLE:
  - req_ready=1, alu_req=0, ALU drive = a 0 / b 0 / PASSB_CODE.
  - On req_valid: mcand<=op_a, mplr<=op_b, acc<=0, cnt<=0.
  - If op_b==0 go to DONE (result 0); else go to ITER.
- ITER:
  - req_ready=0, alu_req=1.
  - ALU drive (combinational from registers): alu_a=acc, alu_b = mplr[0] ? mcand : 0, alu_ctrl=ADD_CODE.
  - When alu_gnt=1:
    - acc<=alu_w; mcand<=mcand<<1; mplr<=mplr>>1; cnt<=cnt+1.
    - If (mplr>>1)==0 or cnt==WIDTH-1, go to DONE.
  - When alu_gnt=0: no register changes (stall); outputs hold.
- DONE:
  - resp_valid=1, result=acc, result_zero=(acc==0), alu_req=0, ALU drive returns to idle values.
  - On resp_ready: go to IDLE, resp_valid falls the next cycle.
  - result holds its value until the next accept.
- Handshakes:
  - A request is accepted only when req_valid && req_ready.
  - A response is consumed only when resp_valid && resp_ready.
  - No new request is accepted in the same cycle a response is consumed (req_ready is only high in IDLE).
- Latency with continuous grant:
  - Let N = 1 + index of the highest set bit of op_b.
  - resp_valid rises at accept+N+1 edges.
  - op_b==0 gives accept+1.
  - Each cycle with alu_gnt=0 adds one cycle.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH; carries out of the ALU add and bits shifted out of mcand are discarded.
  - Maximum ITER count is WIDTH (op_b MSB set).
- alu_req and alu_ctrl are Moore outputs (state/registers only); no combinational path from alu_gnt or alu_w to any output.
- req_valid and op_* are ignored outside IDLE.

Test Plan:
- Reset held 2 cycles, then released -> req_ready=1, resp_valid=0, result=0, result_zero=1, alu_ctrl=4'b0111, alu_req=0.
- op_a=7, op_b=5, alu_gnt=1 constantly, resp_ready=1 -> alu_b sequence 7,0,28; resp_valid at accept+4; result=35, result_zero=0.
- op_a=123, op_b=0 -> no alu_req ever; resp_valid at accept+1; result=0, result_zero=1.
- op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=64'h8000_0000_0000_0000 -> 64 ITER cycles; result=64'h8000_0000_0000_0000 (overflow discarded).
- op_a=3, op_b=3, alu_gnt low on the first two ITER cycles -> acc unchanged while stalled; resp_valid at accept+5; result=9.
- op_a=6, op_b=9 with resp_ready=0 for 3 cycles after DONE -> resp_valid and result=54 held steady, req_ready=0; Reset asserted mid-ITER on a second request -> IDLE next edge with all reset values.
